// File: rtl/fc_tx_frame_gen.sv
// fc_tx_frame_gen: frame writer for the MAC transmit FIFO interface (ff_tx_*).
// Runs in the ff_tx_clk domain. A start pulse latches the run configuration
// and emits frm_count frames of frm_words 32-bit words. The inter-frame gap is
// programmable. Each word carries {frame_idx[15:0], word_idx[15:0]} so the
// receive side can check it.
//
// Ports
//   ff_tx_clk, reset_ff_tx_clk : clock, synchronous active-high reset
//   start, abort               : run control pulses
//   frm_count, frm_words       : frames per run (0 = until abort), words per frame (0 = 1)
//   last_mod                   : ff_tx_mod value placed on each EOP word
//   frm_class, frm_end_code    : copied to ff_tx_class / ff_tx_end_code for the run
//   gap_cycles                 : idle cycles between EOP accept and the next SOP
//   ff_tx_rdy                  : MAC FIFO ready; a word transfers on wren & rdy
//   ff_tx_*                    : FIFO write side (data/sop/eop/mod/err/wren/class/end_code)
//   busy, done, frames_sent    : run status
module fc_tx_frame_gen #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned WLEN_W = 12,
  parameter int unsigned GAP_W  = 8
) (
  input  logic              ff_tx_clk,
  input  logic              reset_ff_tx_clk,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  frm_count,
  input  logic [WLEN_W-1:0] frm_words,
  input  logic [1:0]        last_mod,
  input  logic [3:0]        frm_class,
  input  logic [3:0]        frm_end_code,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic              ff_tx_rdy,
  output logic [31:0]       ff_tx_data,
  output logic              ff_tx_sop,
  output logic              ff_tx_eop,
  output logic [1:0]        ff_tx_mod,
  output logic              ff_tx_err,
  output logic              ff_tx_wren,
  output logic [3:0]        ff_tx_class,
  output logic [3:0]        ff_tx_end_code,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  frames_sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  frame_q, frame_n;
  logic [WLEN_W-1:0] word_q, word_n;
  logic [GAP_W-1:0]  gap_q, gap_n;
  logic [CNT_W-1:0]  cnt_cfg_q, cnt_cfg_n;
  logic [WLEN_W-1:0] last_cfg_q, last_cfg_n;
  logic [1:0]        mod_cfg_q, mod_cfg_n;
  logic [3:0]        class_cfg_q, class_cfg_n;
  logic [3:0]        endc_cfg_q, endc_cfg_n;
  logic [GAP_W-1:0]  gap_cfg_q, gap_cfg_n;
  logic [CNT_W-1:0]  sent_q, sent_n;
  logic              abort_q, abort_n;
  logic              done_q, done_n;

  logic accept;
  logic last_word;
  logic final_frame;

  always_comb begin
    state_n     = state_q;
    frame_n     = frame_q;
    word_n      = word_q;
    gap_n       = gap_q;
    cnt_cfg_n   = cnt_cfg_q;
    last_cfg_n  = last_cfg_q;
    mod_cfg_n   = mod_cfg_q;
    class_cfg_n = class_cfg_q;
    endc_cfg_n  = endc_cfg_q;
    gap_cfg_n   = gap_cfg_q;
    sent_n      = sent_q;
    abort_n     = abort_q;
    done_n      = 1'b0;

    accept      = (state_q == SEND) && ff_tx_rdy;
    last_word   = (word_q == last_cfg_q);
    final_frame = (cnt_cfg_q != '0) && (frame_q == cnt_cfg_q - CNT_W'(1));

    unique case (state_q)
      IDLE: begin
        // Abort in the same cycle as start wins: nothing is launched.
        if (start && !abort) begin
          state_n     = SEND;
          cnt_cfg_n   = frm_count;
          last_cfg_n  = (frm_words == '0) ? '0 : frm_words - WLEN_W'(1);
          mod_cfg_n   = last_mod;
          class_cfg_n = frm_class;
          endc_cfg_n  = frm_end_code;
          gap_cfg_n   = gap_cycles;
          frame_n     = '0;
          word_n      = '0;
          sent_n      = '0;
          abort_n     = 1'b0;
        end
      end

      SEND: begin
        if (accept) begin
          if (abort_q) begin
            // Abort-terminated frame end accepted: run over, frame not counted.
            state_n = IDLE;
            abort_n = 1'b0;
            done_n  = 1'b1;
          end else if (last_word) begin
            if (sent_q != '1) begin
              sent_n = sent_q + CNT_W'(1);
            end
            // An abort coinciding with a normal EOP accept lets that frame
            // complete and count, then ends the run.
            if (final_frame || abort) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              frame_n = frame_q + CNT_W'(1);
              word_n  = '0;
              if (gap_cfg_q != '0) begin
                state_n = GAP;
                gap_n   = gap_cfg_q;
              end
            end
          end else begin
            word_n = word_q + WLEN_W'(1);
            // The word just accepted had no EOP, so the next one closes the frame.
            if (abort) begin
              abort_n = 1'b1;
            end
          end
        end else if (abort) begin
          abort_n = 1'b1;
        end
      end

      GAP: begin
        if (abort) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (gap_q <= GAP_W'(1)) begin
          state_n = SEND;
        end else begin
          gap_n = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Word outputs depend only on registered state, so they stay put while
    // rdy is low; only a pending abort turns the held word into a frame end.
    ff_tx_wren     = (state_q == SEND);
    ff_tx_data     = ff_tx_wren ? {16'(frame_q), 16'(word_q)} : '0;
    ff_tx_sop      = ff_tx_wren && (word_q == '0);
    ff_tx_eop      = ff_tx_wren && (last_word || abort_q);
    ff_tx_mod      = (ff_tx_wren && last_word && !abort_q) ? mod_cfg_q : '0;
    ff_tx_err      = ff_tx_wren && abort_q;
    ff_tx_class    = class_cfg_q;
    ff_tx_end_code = endc_cfg_q;
    busy           = (state_q != IDLE);
    done           = done_q;
    frames_sent    = sent_q;
  end

  always_ff @(posedge ff_tx_clk) begin
    if (reset_ff_tx_clk) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      word_q      <= '0;
      gap_q       <= '0;
      cnt_cfg_q   <= '0;
      last_cfg_q  <= '0;
      mod_cfg_q   <= '0;
      class_cfg_q <= '0;
      endc_cfg_q  <= '0;
      gap_cfg_q   <= '0;
      sent_q      <= '0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      frame_q     <= frame_n;
      word_q      <= word_n;
      gap_q       <= gap_n;
      cnt_cfg_q   <= cnt_cfg_n;
      last_cfg_q  <= last_cfg_n;
      mod_cfg_q   <= mod_cfg_n;
      class_cfg_q <= class_cfg_n;
      endc_cfg_q  <= endc_cfg_n;
      gap_cfg_q   <= gap_cfg_n;
      sent_q      <= sent_n;
      abort_q     <= abort_n;
      done_q      <= done_n;
    end
  end

endmodule

// File: tb/tb_fc_tx_frame_gen.sv
// Self-checking bench for fc_tx_frame_gen: table-driven runs plus hand-written
// abort, continuous-run, start/abort collision and mid-frame reset sequences.
// Expected words are pushed to a queue at start and popped on every accept.
module tb_fc_tx_frame_gen;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WLEN_W = 12;
  localparam int unsigned GAP_W  = 8;

  logic              clk = 1'b0;
  logic              reset_ff_tx_clk;
  logic              start, abort;
  logic [CNT_W-1:0]  frm_count;
  logic [WLEN_W-1:0] frm_words;
  logic [1:0]        last_mod;
  logic [3:0]        frm_class, frm_end_code;
  logic [GAP_W-1:0]  gap_cycles;
  logic              ff_tx_rdy;
  logic [31:0]       ff_tx_data;
  logic              ff_tx_sop, ff_tx_eop, ff_tx_err, ff_tx_wren;
  logic [1:0]        ff_tx_mod;
  logic [3:0]        ff_tx_class, ff_tx_end_code;
  logic              busy, done;
  logic [CNT_W-1:0]  frames_sent;

  always #5 clk = ~clk;

  fc_tx_frame_gen #(.CNT_W(CNT_W), .WLEN_W(WLEN_W), .GAP_W(GAP_W)) dut (
    .ff_tx_clk(clk), .reset_ff_tx_clk(reset_ff_tx_clk), .start(start), .abort(abort),
    .frm_count(frm_count), .frm_words(frm_words), .last_mod(last_mod),
    .frm_class(frm_class), .frm_end_code(frm_end_code), .gap_cycles(gap_cycles),
    .ff_tx_rdy(ff_tx_rdy), .ff_tx_data(ff_tx_data), .ff_tx_sop(ff_tx_sop),
    .ff_tx_eop(ff_tx_eop), .ff_tx_mod(ff_tx_mod), .ff_tx_err(ff_tx_err),
    .ff_tx_wren(ff_tx_wren), .ff_tx_class(ff_tx_class), .ff_tx_end_code(ff_tx_end_code),
    .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  typedef struct {
    int unsigned cnt;
    int unsigned words;
    int unsigned lmod;
    int unsigned gap;
    int unsigned rmode;   // 0: rdy always 1, 1: random rdy
    int unsigned cls;
    int unsigned endc;
    int unsigned exp_sent;
  } vec_t;

  vec_t vecs[6];

  int tests = 0;
  int fails = 0;
  logic [44:0] exp_q[$];
  int unsigned cur_gap = 0;
  int unsigned rdy_mode = 0;   // 2: driven by the main sequence

  logic [44:0] cur;
  assign cur = {ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_err, ff_tx_class, ff_tx_end_code};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [44:0] mkw(input int unsigned f, input int unsigned w, input logic s,
                                      input logic e, input logic [1:0] m, input logic er,
                                      input logic [3:0] c, input logic [3:0] ec);
    logic [15:0] f16, w16;
    f16 = f[15:0];
    w16 = w[15:0];
    return {f16, w16, s, e, m, er, c, ec};
  endfunction

  task automatic push_run(input vec_t v, input int unsigned frames);
    int unsigned last;
    last = (v.words == 0) ? 0 : v.words - 1;
    for (int unsigned f = 0; f < frames; f++)
      for (int unsigned w = 0; w <= last; w++)
        exp_q.push_back(mkw(f, w, w == 0, w == last, (w == last) ? v.lmod[1:0] : 2'b00, 1'b0,
                            v.cls[3:0], v.endc[3:0]));
  endtask

  task automatic drive_cfg(input vec_t v);
    frm_count    = v.cnt[CNT_W-1:0];
    frm_words    = v.words[WLEN_W-1:0];
    last_mod     = v.lmod[1:0];
    frm_class    = v.cls[3:0];
    frm_end_code = v.endc[3:0];
    gap_cycles   = v.gap[GAP_W-1:0];
    cur_gap      = v.gap;
  endtask

  task automatic start_run(input vec_t v);
    @(posedge clk); #1;
    drive_cfg(v);
    rdy_mode = v.rmode;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Config inputs may change freely once the run has started.
    frm_count    = CNT_W'($urandom);
    frm_words    = WLEN_W'($urandom);
    last_mod     = 2'($urandom);
    frm_class    = 4'($urandom);
    frm_end_code = 4'($urandom);
    gap_cycles   = GAP_W'($urandom);
    @(negedge clk);
    chk("latency_wren_sop", {ff_tx_wren, ff_tx_sop}, 2'b11);
  endtask

  task automatic wait_done(input int unsigned exp_sent);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("busy_at_done", busy, 0);
      chk("frames_sent", frames_sent, exp_sent);
      chk("queue_drained", exp_q.size(), 0);
      @(negedge clk);
      chk("done_pulse_width", done, 0);
    end
    exp_q.delete();
  endtask

  // rdy generator for table runs
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) ff_tx_rdy = 1'b1;
    else if (rdy_mode == 1) ff_tx_rdy = 1'($urandom_range(0, 1));
  end

  // Monitor: scoreboard pop on accept, hold stability, gap length.
  logic [44:0] prev_w = '0;
  logic prev_held = 1'b0, prev_abort = 1'b0, gap_arm = 1'b0;
  int unsigned gap_seen = 0;
  always @(negedge clk) begin
    if (reset_ff_tx_clk) begin
      prev_held = 1'b0;
      gap_arm   = 1'b0;
    end else begin
      if (done) gap_arm = 1'b0;
      if (gap_arm) begin
        if (!ff_tx_wren) gap_seen++;
        else begin
          chk("gap_len", gap_seen, cur_gap);
          gap_arm = 1'b0;
        end
      end
      if (prev_held && ff_tx_wren && !prev_abort) chk("hold_stable", cur, prev_w);
      if (ff_tx_wren && ff_tx_rdy) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got 0x%0h expected no transfer", cur);
        end else begin
          chk("word", cur, exp_q.pop_front());
        end
        if (ff_tx_eop) begin
          gap_arm  = 1'b1;
          gap_seen = 0;
        end
      end
      prev_held  = ff_tx_wren && !ff_tx_rdy;
      prev_w     = cur;
      prev_abort = abort;
    end
  end

  initial begin
    vec_t v;
    bit found;
    vecs[0] = '{2, 3, 2, 2, 0, 4'h3, 4'hA, 2};
    vecs[1] = '{2, 3, 2, 2, 1, 4'h3, 4'hA, 2};
    vecs[2] = '{3, 0, 1, 0, 0, 4'h1, 4'h2, 3};
    vecs[3] = '{4, 1, 3, 3, 1, 4'hF, 4'h5, 4};
    vecs[4] = '{2, 5, 3, 0, 1, 4'h6, 4'hC, 2};
    vecs[5] = '{3, 2, 0, 1, 1, 4'h9, 4'h0, 3};

    reset_ff_tx_clk = 1'b1;
    start = 1'b0; abort = 1'b0;
    frm_count = '0; frm_words = '0; last_mod = '0;
    frm_class = '0; frm_end_code = '0; gap_cycles = '0;
    ff_tx_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_err, ff_tx_wren,
                          ff_tx_class, ff_tx_end_code, busy, done, frames_sent}, 64'h0);
    @(posedge clk); #1;
    reset_ff_tx_clk = 1'b0;

    for (int i = 0; i < 6; i++) begin
      push_run(vecs[i], vecs[i].cnt);
      start_run(vecs[i]);
      wait_done(vecs[i].exp_sent);
      repeat (2) @(negedge clk);
      chk("idle_after_run", {ff_tx_wren, busy}, 2'b00);
    end

    // Abort while word 2 is held with rdy=0.
    @(posedge clk); #1;
    rdy_mode = 2;
    ff_tx_rdy = 1'b1;
    v = '{1, 5, 3, 0, 2, 4'h5, 4'h9, 0};
    drive_cfg(v);
    exp_q.push_back(mkw(0, 0, 1'b1, 1'b0, 2'b00, 1'b0, 4'h5, 4'h9));
    exp_q.push_back(mkw(0, 1, 1'b0, 1'b0, 2'b00, 1'b0, 4'h5, 4'h9));
    exp_q.push_back(mkw(0, 2, 1'b0, 1'b1, 2'b00, 1'b1, 4'h5, 4'h9));
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; ff_tx_rdy = 1'b0;
    @(posedge clk); #1;
    chk("held_word2", {ff_tx_data, ff_tx_eop, ff_tx_err}, {32'h2, 1'b0, 1'b0});
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("abort_frame_end", {ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_err, ff_tx_wren},
        {32'h2, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1});
    @(posedge clk); #1; ff_tx_rdy = 1'b1;
    wait_done(0);
    rdy_mode = 0;

    // Continuous run, aborted during the gap after the third frame.
    v = '{0, 2, 1, 1, 0, 4'h2, 4'h7, 3};
    push_run(v, 3);
    start_run(v);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frames_sent == 3 && !ff_tx_wren && busy) begin
        abort = 1'b1;
        found = 1'b1;
        break;
      end
    end
    chk("reached_gap_3", found, 1);
    @(posedge clk); #1; abort = 1'b0;
    wait_done(3);
    repeat (4) @(negedge clk);
    chk("no_wren_after_gap_abort", ff_tx_wren, 0);

    // Start and abort together in IDLE: nothing launched.
    @(posedge clk); #1;
    drive_cfg('{1, 1, 0, 0, 0, 4'h1, 4'h1, 0});
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", {ff_tx_wren, busy, done}, 3'b000);
    repeat (3) @(negedge clk);

    // Reset mid-frame, then a fresh run restarts from word 0 of frame 0.
    v = '{3, 4, 1, 0, 0, 4'hB, 4'hD, 0};
    push_run(v, 3);
    start_run(v);
    @(posedge clk); #1;
    reset_ff_tx_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_midframe_outputs", {ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_err, ff_tx_wren,
                                   ff_tx_class, ff_tx_end_code, busy, done, frames_sent}, 64'h0);
    @(posedge clk); #1;
    reset_ff_tx_clk = 1'b0;
    exp_q.delete();
    v = '{1, 2, 2, 0, 0, 4'h4, 4'h8, 1};
    push_run(v, 1);
    start_run(v);
    chk("restart_data", ff_tx_data, 32'h0);
    wait_done(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
